ff_arith_unit: RTL

- Parametrised GF(2^M) arithmetic unit in polynomial basis; generalises the combinational 163-bit field adder.
- Adds a bit-serial, MSB-first field multiplier with configurable reduction polynomial and a start/busy/done handshake.
- Used by the ECC point-arithmetic controller for field add and multiply.
- Default configuration is the sect163 binary field: x^163 + x^7 + x^6 + x^3 + 1.

---
 rtl/ff_arith_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ff_arith_unit.sv
// rtl/ff_arith_unit.sv - GF(2^M) adder and bit-serial MSB-first multiplier; FF_ARITH_MAC_EN enables op=10 multiply-accumulate
module ff_arith_unit #(
    parameter int            M    = 163,
    parameter logic [M-1:0]  POLY = M'(163'hC9)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] c,
    output logic         busy,
    output logic         done
);
    localparam int            CW       = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [M-1:0]   r_ra;
    logic [M-1:0]   r_rb;
    logic [M-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [M-1:0]   r_c;
    logic           r_done;
    logic           r_busy;

    logic           w_accept;
    logic           w_is_add;
    logic           w_is_mul;
    logic           w_last;
    logic [M-1:0]   w_shift;
    logic [M-1:0]   w_acc_nxt;
    logic [M-1:0]   w_c_nxt;
    logic           w_c_load;
    logic           w_done_nxt;

`ifdef FF_ARITH_MAC_EN
    logic [M-1:0]   r_cold;
    logic           r_mac;
`endif

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_add = (op == 2'b00);
    assign w_is_mul = (op == 2'b01) || (op == 2'b10);
    assign w_last   = (r_cnt == '0);

    // One Horner step: multiply accumulator by x mod POLY, then add ra if this bit of rb is set.
    assign w_shift   = {r_acc[M-2:0], 1'b0} ^ (r_acc[M-1] ? POLY : '0);
    assign w_acc_nxt = w_shift ^ (r_rb[r_cnt] ? r_ra : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_last)               w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        w_c_load   = 1'b0;
        w_c_nxt    = r_c;
        if (r_state == S_IDLE && w_accept && w_is_add) begin
            w_done_nxt = 1'b1;
            w_c_load   = 1'b1;
            w_c_nxt    = a ^ b;
        end else if (r_state == S_MUL && w_last) begin
            w_done_nxt = 1'b1;
            w_c_load   = 1'b1;
`ifdef FF_ARITH_MAC_EN
            w_c_nxt    = w_acc_nxt ^ (r_mac ? r_cold : '0);
`else
            w_c_nxt    = w_acc_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_c    <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
`ifdef FF_ARITH_MAC_EN
            r_cold <= '0;
            r_mac  <= 1'b0;
`endif
        end else begin
            r_done <= w_done_nxt;
            if (w_c_load) r_c <= w_c_nxt;
            if (r_state == S_IDLE && w_accept && w_is_mul) begin
                r_ra   <= a;
                r_rb   <= b;
                r_acc  <= '0;
                r_cnt  <= CNT_LAST;
                r_busy <= 1'b1;
`ifdef FF_ARITH_MAC_EN
                r_cold <= r_c;
                r_mac  <= (op == 2'b10);
`endif
            end else if (r_state == S_MUL) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) r_busy <= 1'b0;
            end
        end
    end

    assign c    = r_c;
    assign busy = r_busy;
    assign done = r_done;
endmodule
